// File: rtl/uart_frame_fmt_if.sv
// Handshake bundle between the scan-code capture side, the frame formatter
// and the UART transmitter.
interface uart_frame_fmt_if #(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 3
);
  logic [CNT_W-1:0]       bcount;
  logic [8*MAX_BYTES-1:0] tbuf;
  logic                   start;
  logic                   ready;
  logic                   tstart;
  logic                   tready;
  logic [7:0]             tbus;
  logic                   done;
  logic                   drop;

  modport master (
    output bcount, tbuf, start, tready,
    input  ready, tstart, tbus, done, drop
  );

  modport slave (
    input  bcount, tbuf, start, tready,
    output ready, tstart, tbus, done, drop
  );
endinterface

// File: rtl/uart_frame_fmt.sv
// Formats a captured scan-code buffer into a UART character stream
// (hex-ASCII or raw, separator between bytes) terminated by CR LF.
module uart_frame_fmt #(
  parameter int         MAX_BYTES = 4,
  parameter int         CNT_W     = 3,
  parameter int         HEX_MODE  = 1,
  parameter logic [7:0] SEP       = 8'h20
) (
  input logic             clk,
  input logic             rstn,
  uart_frame_fmt_if.slave bus
);

  localparam int TOTAL_MAX = 3 * MAX_BYTES + 1;
  localparam int IDX_W     = (TOTAL_MAX > 1) ? $clog2(TOTAL_MAX) : 1;
  localparam int PER_BYTE  = (HEX_MODE != 0) ? 3 : 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             tbus_q, tbus_d;
  logic                   tstart_q, tstart_d;
  logic                   hold_q, hold_d;
  logic                   done_c;
  logic                   last_c;

  function automatic logic [7:0] hex_digit(input logic [3:0] v);
    logic [7:0] c;
    c = (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    return c;
  endfunction

  // Character idx of a frame of n bytes: each byte slot is PER_BYTE wide,
  // the last byte's separator slot is replaced by CR, then LF follows.
  function automatic logic [7:0] char_at(input int idx, input int n,
                                         input logic [8*MAX_BYTES-1:0] b);
    int         pos;
    int         ph;
    int         k;
    logic [7:0] byt;
    logic [7:0] c;
    byt = 8'h00;
    c   = 8'h0A;
    if (idx == PER_BYTE * n - 1) begin
      c = 8'h0D;
    end else if (idx < PER_BYTE * n - 1) begin
      pos = idx / PER_BYTE;
      ph  = idx % PER_BYTE;
      k   = n - 1 - pos;
      if (k >= 0 && k < MAX_BYTES) byt = b[8*k +: 8];
      if (HEX_MODE != 0) begin
        case (ph)
          0:       c = hex_digit(byt[7:4]);
          1:       c = hex_digit(byt[3:0]);
          default: c = SEP;
        endcase
      end else begin
        c = (ph == 0) ? byt : SEP;
      end
    end
    return c;
  endfunction

  assign last_c = (int'(idx_q) == PER_BYTE * int'(n_q));

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    n_d      = n_q;
    idx_d    = idx_q;
    tbus_d   = tbus_q;
    tstart_d = 1'b0;
    hold_d   = hold_q;
    done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.bcount != '0)) begin
          buf_d   = bus.tbuf;
          n_d     = (bus.bcount > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bus.bcount;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.tready) begin
          tbus_d   = char_at(int'(idx_q), int'(n_q), buf_q);
          tstart_d = 1'b1;
          hold_d   = 1'b0;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never lowers tready is assumed to have taken
        // the character after two idle-looking cycles.
        if (!bus.tready || hold_q) begin
          state_d = WAIT_DONE;
        end else begin
          hold_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tready) begin
          if (last_c) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      tbus_q   <= '0;
      tstart_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      tbus_q   <= tbus_d;
      tstart_q <= tstart_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.tstart = tstart_q;
  assign bus.tbus   = tbus_q;
  assign bus.done   = done_c;
  // done and drop are decoded from the current state so a start landing on
  // the done cycle is still seen as busy.
  assign bus.drop   = bus.start && (state_q != IDLE) && (bus.bcount != '0);

endmodule

// File: doc/uart_frame_fmt.md
Name: uart_frame_fmt

Overview:
- Formats a captured buffer of up to MAX_BYTES bytes (keyboard scan codes) into a UART character stream, then appends CR LF.
- Sits between the scan-code capture logic and the UART transmitter, replacing the fixed 4-byte formatter.
- Adds a hex-ASCII mode, a configurable byte count, a configurable separator, and a robust transmitter handshake.
- Adds `done` and `drop` status strobes.

Parameters:
- MAX_BYTES, 4: maximum bytes per frame; must be at least 1.
- CNT_W, 3: width of `bcount`; must satisfy 2^CNT_W > MAX_BYTES.
- HEX_MODE, 1: 1 = each byte sent as two uppercase ASCII hex digits; 0 = raw byte.
- SEP, 8'h20: separator character inserted between bytes.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- bcount  in  CNT_W  number of valid bytes in `tbuf`; 0 means nothing to send.
- tbuf  in  8*MAX_BYTES  byte k is tbuf[8k+7:8k].
- start  in  1  request to send a frame; sampled only when `ready` = 1.
- ready  out  1  block is idle and able to accept `start`.
- tstart  out  1  one-cycle pulse to the UART transmitter: send `tbus`.
- tready  in  1  UART transmitter is idle.
- tbus  out  8  character to transmit; registered.
- done  out  1  one-cycle pulse when the final LF has been fully transmitted.
- drop  out  1  one-cycle pulse when a `start` was ignored because the block was busy.

Behaviour:
- Reset (rstn = 0, asynchronous):
  - State = IDLE; `tstart`, `tbus`, `done`, `drop` = 0; captured buffer and counters cleared.
  - `ready` = 1 immediately.
  - Reset mid-frame aborts the frame; no further `tstart` is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - `ready` is 1 only in IDLE.
- IDLE:
  - If start = 1 and bcount != 0: capture `tbuf` and n = min(bcount, MAX_BYTES); set the character index to 0; go to ISSUE.
  - If bcount = 0: `start` is ignored, with no `drop`.
- Character sequence:
  - Bytes are sent most-significant first: byte n-1 down to byte 0.
  - HEX_MODE = 1:
    - Each byte produces its high nibble digit, then its low nibble digit.
    - Digits 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46.
    - SEP is inserted between bytes, never after the last byte.
    - Total characters = 3n+1.
  - HEX_MODE = 0:
    - Raw bytes, with SEP between bytes.
    - Total characters = 2n+1.
  - The frame always ends with 8'h0D then 8'h0A.
- ISSUE:
  - Wait for tready = 1.
  - In that cycle, register `tbus` with the current character and pulse `tstart` for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for tready = 0 (transmitter has accepted the character); go to WAIT_DONE.
  - If `tready` stays 1 for 2 cycles after `tstart`, treat the character as accepted and go to WAIT_DONE. This covers zero-latency transmitters.
- WAIT_DONE:
  - Wait for tready = 1.
  - If more characters remain: increment the index and go to ISSUE. The next `tstart` follows one cycle later at the earliest.
  - After the final LF: pulse `done` for one cycle and go to IDLE.
- `tbus` holds its value from `tstart` until the next character is issued. After the frame it keeps the LF (8'h0A).
- `drop`: pulses for one cycle in any cycle where start = 1, the state is not IDLE, and bcount != 0. The frame in progress is unaffected.
- Same-cycle `done` and `start`: the state is still WAIT_DONE in that cycle, so `start` is dropped. `start` is accepted on the following cycle.
- Width rules:
  - The index counter is sized for 3*MAX_BYTES+1 characters.
  - The clamp compares `bcount` at CNT_W bits; no wrap-around is permitted.
- Changes on `tbuf` and `bcount` after capture have no effect on the frame in progress.

Test Plan:
- HEX_MODE = 1, tbuf = 32'h0000_3CA5, bcount = 2, start pulse, transmitter model with 10-cycle busy:
  - `tbus` sequence must be 33 43 20 41 35 0D 0A.
  - Exactly 7 `tstart` pulses, then 1 `done`; `ready` returns to 1.
- HEX_MODE = 0, tbuf = 32'hF0E1_D2C3, bcount = 4:
  - Sequence must be F0 20 E1 20 D2 20 C3 0D 0A.
  - No `tstart` may occur while tready = 0.
- bcount = 7 with MAX_BYTES = 4:
  - Frame is clamped to 4 bytes: 13 characters in hex mode.
- bcount = 0 with start:
  - No `tstart`, no `drop`; `ready` stays 1.
- start pulsed mid-frame:
  - `drop` = 1 for one cycle; original frame completes unchanged; no second frame follows.
- rstn asserted low during the 3rd character:
  - `tstart`, `tbus`, `done` immediately 0; `ready` = 1.
  - After release, a new start sends a complete fresh frame from index 0.
- Transmitter that never drops `tready`:
  - Each character is issued once, and `tstart` pulses are spaced at least 3 cycles apart.
